hv_sync_receiver: RTL

//  Sink end of the HD/VD sensor-timing interface. Samples level-type HD/VD (high = active),

---
 rtl/hv_sync_rx_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 31 +++
 rtl/hv_sync_receiver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hv_sync_rx_pkg.sv
// Shared types and default geometry for the HD/VD sync receiver.
package hv_sync_rx_pkg;

  // Lock state machine: hunt for a frame edge, qualify frames, then hold lock.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  // Default sensor timing. The blanking widths describe the source. The receiver
  // itself only judges the totals, so the blanking widths are not module parameters.
  localparam int H_TOTAL_DEF     = 64;
  localparam int V_TOTAL_DEF     = 32;
  localparam int H_BLANK_DEF     = 7;
  localparam int V_BLANK_DEF     = 1;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int CW_DEF          = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Two-stage input register with rising-edge pulse. Edges are suppressed until
// both stages hold real samples after reset, so the reset value never fakes an edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic       s1_q;
  logic       s2_q;
  logic [1:0] vld_q;

  // Shift the input through two stages and track when the second stage becomes meaningful
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      vld_q <= 2'b00;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
    end
  end

  assign q_o    = s1_q;
  assign rise_o = s1_q & ~s2_q & vld_q[1];

endmodule

// File: rtl/hv_sync_receiver.sv
// HD/VD sink: recovers pixel/line position and data enable, measures line and
// frame geometry, and locks after consecutive frames match the programmed timing.
// Optional statistics ports (frame_cnt, err_cnt) exist when HV_SYNC_RX_STATS_EN is defined.
module hv_sync_receiver
  import hv_sync_rx_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hd,
  input  logic          vd,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] line_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic          h_err,
  output logic          v_err,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_v_total
`ifdef HV_SYNC_RX_STATS_EN
  ,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] err_cnt
`endif
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] H_TOT_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOT_C  = CW'(V_TOTAL);
  localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_FRAMES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic hd_q, vd_q, hd_rise, vd_rise;

  sync_edge_det u_hd_edge (.clk(clk), .rst(rst), .d_i(hd), .q_o(hd_q), .rise_o(hd_rise));
  sync_edge_det u_vd_edge (.clk(clk), .rst(rst), .d_i(vd), .q_o(vd_q), .rise_o(vd_rise));

  logic          de_q, line_start_q, frame_start_q, h_seen_q;
  logic [CW-1:0] h_cnt_q, l_cnt_q, pix_x_q, line_y_q, meas_h_q, meas_v_q;
  logic          de_d;

  rx_state_t     state_q;
  logic [CW-1:0] good_cnt_q;
  logic          frame_bad_q, locked_q, h_err_q, v_err_q;

  // Mismatches are raw comparisons; they only count once the FSM has left SEARCH.
  logic h_mis, v_mis, h_bad, v_bad;
  assign h_mis = hd_rise & h_seen_q & (h_cnt_q != H_TOT_C);
  assign v_mis = vd_rise & (l_cnt_q != V_TOT_C);
  assign h_bad = h_mis & (state_q != SEARCH);
  assign v_bad = v_mis & (state_q != SEARCH);

  assign de_d = hd_q & vd_q;

  // Position counters, geometry measurement and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      h_seen_q      <= 1'b0;
      h_cnt_q       <= '0;
      l_cnt_q       <= '0;
      pix_x_q       <= '0;
      line_y_q      <= '0;
      meas_h_q      <= '0;
      meas_v_q      <= '0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= hd_rise;
      frame_start_q <= vd_rise;

      if (hd_rise) begin
        h_cnt_q  <= ONE_C;
        h_seen_q <= 1'b1;
        // The first line after reset started at an unknown point, so it is not measured
        if (h_seen_q) meas_h_q <= h_cnt_q;
      end else if (h_cnt_q != CNT_MAX) begin
        h_cnt_q <= h_cnt_q + ONE_C;
      end

      // Frame close takes precedence; a coincident HD rise is line 1 of the new frame
      if (vd_rise) begin
        meas_v_q <= l_cnt_q;
        l_cnt_q  <= ONE_C;
      end else if (hd_rise) begin
        l_cnt_q <= l_cnt_q + ONE_C;
      end

      if (de_d && !de_q) pix_x_q <= '0;
      else if (de_d)     pix_x_q <= pix_x_q + ONE_C;

      if (vd_rise)              line_y_q <= '0;
      else if (hd_rise && vd_q) line_y_q <= line_y_q + ONE_C;
    end
  end

  // Lock FSM with registered locked output and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      good_cnt_q  <= '0;
      frame_bad_q <= 1'b0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
    end else begin
      locked_q <= (state_q == LOCKED);
      if (h_bad) h_err_q <= 1'b1;
      if (v_bad) v_err_q <= 1'b1;

      case (state_q)
        SEARCH: begin
          if (vd_rise) begin
            state_q     <= ACQUIRE;
            good_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (vd_rise) begin
            frame_bad_q <= 1'b0;
            if (frame_bad_q || h_mis || v_mis) begin
              good_cnt_q <= '0;
            end else if (good_cnt_q + ONE_C == LOCK_C) begin
              good_cnt_q <= good_cnt_q + ONE_C;
              state_q    <= LOCKED;
            end else begin
              good_cnt_q <= good_cnt_q + ONE_C;
            end
          end else if (h_mis) begin
            frame_bad_q <= 1'b1;
            good_cnt_q  <= '0;
          end
        end
        LOCKED: begin
          if (h_mis || v_mis) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

`ifdef HV_SYNC_RX_STATS_EN
  logic [CW-1:0] frame_cnt_q, err_cnt_q;

  // Frame count wraps; judged mismatch events saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (vd_rise) frame_cnt_q <= frame_cnt_q + ONE_C;
      if ((h_bad || v_bad) && err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + ONE_C;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

  assign de           = de_q;
  assign pix_x        = pix_x_q;
  assign line_y       = line_y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign h_err        = h_err_q;
  assign v_err        = v_err_q;
  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;

endmodule
